// File: rtl/reflet_mem_wait_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_mem_wait_bridge
//  Brief    : Adapts the alignment fixer's single-cycle RAM port to a memory
//             that answers with a mem_ready strobe after a variable wait.
//             Holds the fixer with stall while a request is in flight and
//             flags a sticky bus_error if the memory never answers.
//  Revision : 1.0 - initial release
// ============================================================================
module reflet_mem_wait_bridge #(
    parameter int word_size = 16,
    parameter int addr_size = 16,
    parameter int timeout   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    // alignment fixer side
    input  logic [addr_size-1:0] fix_addr,
    input  logic [word_size-1:0] fix_data_out,
    input  logic                 fix_write_en,
    input  logic                 fix_read_en,
    output logic [word_size-1:0] fix_data_in,
    output logic                 stall,
    // memory side
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data_out,
    output logic                 mem_write_en,
    output logic                 mem_req,
    input  logic                 mem_ready,
    input  logic [word_size-1:0] mem_data_in,
    // status
    output logic                 bus_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last REQ cycle index before giving up on the memory.
    localparam logic [15:0] c_timeout_last = 16'(timeout - 1);

    state_t                 state_q,     state_d;
    logic [15:0]            wait_cnt_q,  wait_cnt_d;
    logic [addr_size-1:0]   mem_addr_q,  mem_addr_d;
    logic [word_size-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   mem_we_q,    mem_we_d;
    logic [word_size-1:0]   rdata_q,     rdata_d;
    logic                   bus_err_q,   bus_err_d;

    logic                   w_fix_req;

    assign w_fix_req = fix_write_en | fix_read_en;

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state logic: capture in IDLE, wait/timeout in REQ, one-cycle DONE.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_fix_req) begin
                    // A simultaneous read+write is resolved as a write.
                    mem_addr_d  = fix_addr;
                    mem_wdata_d = fix_data_out;
                    mem_we_d    = fix_write_en;
                    wait_cnt_d  = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // A late answer on the very last cycle still counts as success.
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_data_in;
                    end
                    state_d = S_DONE;
                end else if (wait_cnt_q == c_timeout_last) begin
                    bus_err_d = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = '1;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall        = ((state_q == S_IDLE) && w_fix_req) || (state_q == S_REQ);
    assign mem_req      = (state_q == S_REQ);
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_wdata_q;
    assign mem_write_en = mem_we_q;
    assign fix_data_in  = rdata_q;
    assign bus_error    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_reflet_mem_wait_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reflet_mem_wait_bridge
//  Brief    : Self-checking bench for reflet_mem_wait_bridge (64-bit words,
//             timeout 16). Expected completions are queued when a request is
//             issued and compared when the bridge reaches DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_mem_wait_bridge;

    localparam int c_WORD    = 64;
    localparam int c_ADDR    = 16;
    localparam int c_TIMEOUT = 16;

    logic              clk;
    logic              reset;
    logic [c_ADDR-1:0] fix_addr;
    logic [c_WORD-1:0] fix_data_out;
    logic              fix_write_en;
    logic              fix_read_en;
    logic [c_WORD-1:0] fix_data_in;
    logic              stall;
    logic [c_ADDR-1:0] mem_addr;
    logic [c_WORD-1:0] mem_data_out;
    logic              mem_write_en;
    logic              mem_req;
    logic              mem_ready;
    logic [c_WORD-1:0] mem_data_in;
    logic              bus_error;

    reflet_mem_wait_bridge #(
        .word_size (c_WORD),
        .addr_size (c_ADDR),
        .timeout   (c_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .fix_addr     (fix_addr),
        .fix_data_out (fix_data_out),
        .fix_write_en (fix_write_en),
        .fix_read_en  (fix_read_en),
        .fix_data_in  (fix_data_in),
        .stall        (stall),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mem_data_in  (mem_data_in),
        .bus_error    (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_WORD-1:0] data;
        logic              err;
    } exp_t;

    exp_t              r_sb[$];
    int                n_checks = 0;
    int                n_errors = 0;
    logic [c_WORD-1:0] m_data   = '0;
    logic              m_err    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " fix_data_in"},  fix_data_in, '0);
        check({tag, " stall"},        {63'd0, stall}, 64'd0);
        check({tag, " mem_req"},      {63'd0, mem_req}, 64'd0);
        check({tag, " mem_write_en"}, {63'd0, mem_write_en}, 64'd0);
        check({tag, " mem_addr"},     {48'd0, mem_addr}, 64'd0);
        check({tag, " mem_data_out"}, mem_data_out, '0);
        check({tag, " bus_error"},    {63'd0, bus_error}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    // One transaction. k = REQ cycle index on which mem_ready rises
    // (negative = never). poke_done raises fix_read_en during DONE.
    task automatic txn(input string tag, input logic [c_ADDR-1:0] addr,
                       input logic [c_WORD-1:0] wdata, input logic we,
                       input logic re, input int k,
                       input logic [c_WORD-1:0] rdata, input logic poke_done);
        logic timed_out;
        logic given;
        exp_t e;
        timed_out = (k < 0) || (k >= c_TIMEOUT);
        if (!we) m_data = timed_out ? {c_WORD{1'b1}} : rdata;
        if (timed_out) m_err = 1'b1;
        e.data = m_data;
        e.err  = m_err;
        r_sb.push_back(e);

        @(negedge clk);
        fix_addr     = addr;
        fix_data_out = wdata;
        fix_write_en = we;
        fix_read_en  = re;
        mem_ready    = (k == 0);
        mem_data_in  = rdata;
        #1;
        check({tag, " idle stall"},   {63'd0, stall}, 64'd1);
        check({tag, " idle mem_req"}, {63'd0, mem_req}, 64'd0);
        @(posedge clk);

        given = 1'b0;
        for (int n = 0; n < c_TIMEOUT; n++) begin
            @(negedge clk);
            fix_write_en = 1'b0;
            fix_read_en  = 1'b0;
            fix_addr     = ~addr;
            fix_data_out = ~wdata;
            #1;
            check({tag, " req mem_req"}, {63'd0, mem_req}, 64'd1);
            check({tag, " req stall"},   {63'd0, stall}, 64'd1);
            check({tag, " req addr"},    {48'd0, mem_addr}, {48'd0, addr});
            check({tag, " req wdata"},   mem_data_out, wdata);
            check({tag, " req we"},      {63'd0, mem_write_en}, {63'd0, we});
            if (n == k) begin
                mem_ready = 1'b1;
                given     = 1'b1;
            end
            @(posedge clk);
            if (given) break;
        end

        @(negedge clk);
        mem_ready   = 1'b0;
        mem_data_in = ~rdata;
        if (poke_done) fix_read_en = 1'b1;
        #1;
        check({tag, " done mem_req"}, {63'd0, mem_req}, 64'd0);
        check({tag, " done stall"},   {63'd0, stall}, 64'd0);
        if (r_sb.size() == 0) begin
            check({tag, " sb empty"}, 64'd1, 64'd0);
        end else begin
            e = r_sb.pop_front();
            check({tag, " fix_data_in"}, fix_data_in, e.data);
            check({tag, " bus_error"},   {63'd0, bus_error}, {63'd0, e.err});
        end
        fix_read_en = 1'b0;

        // Back in IDLE: nothing in flight, read data held.
        @(negedge clk);
        #1;
        check({tag, " idle2 mem_req"}, {63'd0, mem_req}, 64'd0);
        check({tag, " idle2 stall"},   {63'd0, stall}, 64'd0);
        check({tag, " idle2 hold"},    fix_data_in, m_data);
    endtask

    initial begin
        reset        = 1'b1;
        fix_addr     = '0;
        fix_data_out = '0;
        fix_write_en = 1'b0;
        fix_read_en  = 1'b0;
        mem_ready    = 1'b0;
        mem_data_in  = '0;
        repeat (2) @(negedge clk);
        // Request and mem_ready present during reset must be ignored.
        fix_read_en = 1'b1;
        mem_ready   = 1'b1;
        @(negedge clk);
        fix_read_en = 1'b0;
        mem_ready   = 1'b0;
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        txn("zw_read",  16'd8, 64'h0, 1'b0, 1'b1, 0, 64'hFEDCBA9876543210, 1'b0);
        txn("wait_wr",  16'd4, 64'h88ff, 1'b1, 1'b0, 3, 64'hDEAD, 1'b0);
        txn("tmo_rd",   16'd12, 64'h0, 1'b0, 1'b1, -1, 64'h5555, 1'b0);
        txn("after_to", 16'd8, 64'h0, 1'b0, 1'b1, 0, 64'hCAFE, 1'b1);
        txn("tmo_wr",   16'd20, 64'h77, 1'b1, 1'b0, -1, 64'h1, 1'b0);

        do_reset();
        txn("race",     16'd2, 64'h0, 1'b0, 1'b1, c_TIMEOUT - 1, 64'h1234, 1'b0);
        txn("both",     16'd6, 64'hAA, 1'b1, 1'b1, 1, 64'h99, 1'b0);

        // Reset on the 2nd REQ cycle abandons the read.
        @(negedge clk);
        fix_addr    = 16'h3C;
        fix_read_en = 1'b1;
        @(negedge clk);
        fix_read_en = 1'b0;
        #1;
        check("rst_mid req1", {63'd0, mem_req}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_data = '0;
        m_err  = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        #1;
        check("rst_mid no_done", {63'd0, mem_req}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            txn("rand", 16'($urandom), {$urandom, $urandom}, 1'($urandom),
                1'b1, int'($urandom_range(0, 5)), {$urandom, $urandom}, 1'b0);
        end

        check("sb drained", 64'(r_sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so a stuck design still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/reflet_mem_wait_bridge.md
REFLET_MEM_WAIT_BRIDGE -- requirements
Module: reflet_mem_wait_bridge

Interface
REQ-001 Parameter word_size, default 16, SHALL set the data width of all data ports.
REQ-002 Parameter addr_size, default 16, SHALL set the width of all address ports.
REQ-003 Parameter timeout, default 16, SHALL set the maximum number of REQ-state cycles before a bus error; legal range 2..65535.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 fix_addr  in  addr_size  SHALL be the word address from the alignment fixer.
REQ-007 fix_data_out  in  word_size  SHALL be the write word from the alignment fixer.
REQ-008 fix_write_en  in  1  SHALL be the write request.
REQ-009 fix_read_en  in  1  SHALL be the read request.
REQ-010 fix_data_in  out  word_size  SHALL be the read word returned to the fixer's ram_data_in.
REQ-011 stall  out  1  SHALL be the upstream hold signal.
REQ-012 mem_addr / mem_data_out  out  addr_size / word_size  SHALL be the registered memory address and write data.
REQ-013 mem_write_en  out  1  SHALL be the registered transaction direction.
REQ-014 mem_req  out  1  SHALL be the memory request strobe.
REQ-015 mem_ready  in  1  SHALL be the memory completion strobe.
REQ-016 mem_data_in  in  word_size  SHALL be the memory read data, valid with mem_ready.
REQ-017 bus_error  out  1  SHALL be the sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE; one transaction outstanding at most.
REQ-019 IDLE with fix_write_en or fix_read_en high SHALL capture fix_addr, fix_data_out and direction into the mem_* registers and go to REQ next cycle.
REQ-020 Both fix_write_en and fix_read_en high SHALL be treated as a write.
REQ-021 stall SHALL be combinational: high in IDLE when a request is present, high throughout REQ, low in DONE and in idle IDLE.
REQ-022 mem_req SHALL be high exactly while in REQ; mem_addr, mem_data_out, mem_write_en SHALL hold constant throughout REQ.
REQ-023 REQ with mem_ready high SHALL latch mem_data_in into fix_data_in on reads (unchanged on writes) and go to DONE.
REQ-024 A 16-bit wait counter SHALL clear on entering REQ and increment each REQ cycle without mem_ready.
REQ-025 In the REQ cycle where the counter equals timeout-1 and mem_ready is low, the FSM SHALL set bus_error, load fix_data_in with all ones (reads only), and go to DONE.
REQ-026 mem_ready in the same cycle as the timeout condition SHALL win: normal completion, no error.
REQ-027 DONE SHALL last exactly one cycle, ignore fix_* requests, and return to IDLE.
REQ-028 fix_data_in SHALL hold its value until the next read completion or timeout.
REQ-029 mem_ready outside REQ SHALL be ignored.
REQ-030 Latency: request seen in IDLE at cycle t, mem_ready at cycle t+1+k (k>=0) -> DONE at t+2+k; stall high cycles t..t+1+k, low at t+2+k.
REQ-031 bus_error SHALL stay set until reset; later transactions SHALL proceed normally.

Reset
REQ-032 reset high at a rising edge SHALL force IDLE, counter 0, mem_req 0, mem_write_en 0, mem_addr 0, mem_data_out 0, fix_data_in 0, bus_error 0.
REQ-033 reset during REQ SHALL abandon the transaction; mem_req low from the next cycle; no DONE cycle.
REQ-034 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Zero-wait read: word_size 64, fix_addr 8, fix_read_en 1, mem_ready tied 1, mem_data_in 64'hFEDCBA9876543210 -> mem_req one cycle, stall 2 cycles, fix_data_in 64'hFEDCBA9876543210 in DONE.
REQ-036 Waited write: fix_addr 4, fix_data_out 64'h88ff, fix_write_en 1, mem_ready after 3 REQ cycles -> mem_write_en 1, mem_data_out 64'h88ff stable 4 cycles, fix_data_in unchanged.
REQ-037 Timeout: timeout 16, read, mem_ready held 0 -> after 16 REQ cycles bus_error 1, fix_data_in all ones, DONE, IDLE; next zero-wait read completes with bus_error still 1.
REQ-038 Timeout race: mem_ready first asserted on 16th REQ cycle, mem_data_in 64'h1234 -> bus_error 0, fix_data_in 64'h1234.
REQ-039 Reset mid-REQ: reset pulsed on 2nd REQ cycle -> next cycle all outputs at reset values, stall low with no request.
REQ-040 Simultaneous read and write with fix_data_out 64'hAA -> write transaction, mem_write_en 1, mem_data_out 64'hAA.
